// File: rtl/nfc_command_reset_seq.sv
// NAND reset sequencer: issues FFh/FCh/FAh resets through the ACG CA path to the
// selected ways (parallel or one way at a time) and supervises each way's R/B line.
module nfc_command_reset_seq #(
  parameter int                      NumberOfWays = 4,
  parameter logic [5:0]              CommandID    = 6'b000001,
  parameter logic [4:0]              TargetID     = 5'b00101,
  parameter int                      RBLowWindow  = 64,
  parameter int                      TimeoutWidth = 24,
  parameter logic [TimeoutWidth-1:0] TimeoutLimit = 24'hFFFFFF
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic [5:0]              iOpcode,
  input  logic [4:0]              iTargetID,
  input  logic [4:0]              iSourceID,
  input  logic [31:0]             iAddress,
  input  logic                    iCMDValid,
  output logic                    oCMDReady,
  input  logic [NumberOfWays-1:0] iWaySelect,
  output logic                    oStart,
  output logic                    oLastStep,
  output logic [NumberOfWays-1:0] oWayTimeout,
  output logic [7:0]              oACG_Command,
  output logic [2:0]              oACG_CommandOption,
  input  logic [7:0]              iACG_Ready,
  input  logic [7:0]              iACG_LastStep,
  output logic [NumberOfWays-1:0] oACG_TargetWay,
  output logic [15:0]             oACG_NumOfData,
  output logic                    oACG_CASelect,
  output logic [39:0]             oACG_CAData,
  input  logic [NumberOfWays-1:0] iACG_ReadyBusy
);

  localparam int                 LowCntW = $clog2(RBLowWindow + 1);
  localparam logic [LowCntW-1:0] LowLast = LowCntW'(RBLowWindow - 1);

  typedef enum logic [3:0] {
    IDLE, SELWAY, CMDISSUE, CMDWAIT, ADDRISSUE,
    ADDRWAIT, WAITRBLOW, WAITRBHIGH, NEXTWAY, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic                    seq_q, seq_d;
  logic [7:0]              lun_q, lun_d;
  logic [NumberOfWays-1:0] mask_q, mask_d;
  logic [NumberOfWays-1:0] remain_q, remain_d;
  logic [NumberOfWays-1:0] target_q, target_d;
  logic [NumberOfWays-1:0] timeout_q, timeout_d;
  logic [NumberOfWays-1:0] rbStage1_q, rbStage2_q;
  logic [LowCntW-1:0]      lowCnt_q, lowCnt_d;
  logic [TimeoutWidth-1:0] toCnt_q, toCnt_d;

  logic                    accept;
  logic                    acgIdle;
  logic                    caDone;
  logic                    wRB;
  logic                    rbHigh;
  logic                    caActive;
  logic                    addrPhase;
  logic [7:0]              cmdByte;
  logic [NumberOfWays-1:0] lowestWay;
  logic                    unusedInputs;

  assign unusedInputs = ^{iSourceID, iAddress[31:16], iAddress[7:5], iAddress[3:2],
                          iACG_Ready[7], iACG_LastStep[7], iACG_LastStep[5:0]};

  assign oStart    = (iOpcode == CommandID) && (iTargetID == TargetID) && iCMDValid;
  assign accept    = oStart && (state_q == IDLE);
  assign acgIdle   = &iACG_Ready[6:0];
  assign caDone    = iACG_LastStep[6];
  assign lowestWay = remain_q & (~remain_q + NumberOfWays'(1));

  // Parallel mode only counts as ready once every selected way has released R/B.
  assign wRB    = |rbStage2_q;
  assign rbHigh = seq_q ? wRB : &(rbStage2_q | ~mask_q);

  always_comb begin
    case (mode_q)
      2'b01:   cmdByte = 8'hFC;
      2'b10:   cmdByte = 8'hFA;
      default: cmdByte = 8'hFF;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    seq_d     = seq_q;
    lun_d     = lun_q;
    mask_d    = mask_q;
    remain_d  = remain_q;
    target_d  = target_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d    = iAddress[1:0];
          seq_d     = iAddress[4];
          lun_d     = iAddress[15:8];
          mask_d    = iWaySelect;
          remain_d  = iWaySelect;
          timeout_d = '0;
          state_d   = SELWAY;
        end
      end
      SELWAY: begin
        if (remain_q == '0) begin
          state_d = NEXTWAY;
        end else begin
          target_d = seq_q ? lowestWay : remain_q;
          state_d  = CMDISSUE;
        end
      end
      CMDISSUE:  if (acgIdle) state_d = CMDWAIT;
      CMDWAIT:   if (caDone) state_d = (mode_q == 2'b10) ? ADDRISSUE : WAITRBLOW;
      ADDRISSUE: if (acgIdle) state_d = ADDRWAIT;
      ADDRWAIT:  if (caDone) state_d = WAITRBLOW;
      WAITRBLOW: if (!wRB || (lowCnt_q == LowLast)) state_d = WAITRBHIGH;
      WAITRBHIGH: begin
        if (rbHigh) begin
          state_d = NEXTWAY;
        end else if (toCnt_q == TimeoutLimit) begin
          timeout_d = timeout_q | target_q;
          state_d   = NEXTWAY;
        end
      end
      NEXTWAY: begin
        remain_d = remain_q & ~target_q;
        state_d  = (remain_d != '0) ? SELWAY : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Both supervision counters restart on any state change and stick at all-ones.
  always_comb begin
    lowCnt_d = lowCnt_q;
    toCnt_d  = toCnt_q;
    if (state_d != state_q) begin
      lowCnt_d = '0;
      toCnt_d  = '0;
    end else begin
      if ((state_q == WAITRBLOW) && (lowCnt_q != '1)) lowCnt_d = lowCnt_q + LowCntW'(1);
      if ((state_q == WAITRBHIGH) && (toCnt_q != '1)) toCnt_d = toCnt_q + TimeoutWidth'(1);
    end
  end

  always_ff @(posedge iSystemClock or negedge iReset) begin
    if (!iReset) begin
      state_q    <= IDLE;
      mode_q     <= 2'b00;
      seq_q      <= 1'b0;
      lun_q      <= 8'h00;
      mask_q     <= '0;
      remain_q   <= '0;
      target_q   <= '0;
      timeout_q  <= '0;
      rbStage1_q <= '0;
      rbStage2_q <= '0;
      lowCnt_q   <= '0;
      toCnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      seq_q      <= seq_d;
      lun_q      <= lun_d;
      mask_q     <= mask_d;
      remain_q   <= remain_d;
      target_q   <= target_d;
      timeout_q  <= timeout_d;
      rbStage1_q <= target_q & iACG_ReadyBusy;
      rbStage2_q <= rbStage1_q;
      lowCnt_q   <= lowCnt_d;
      toCnt_q    <= toCnt_d;
    end
  end

  assign caActive  = state_q inside {CMDISSUE, CMDWAIT, ADDRISSUE, ADDRWAIT};
  assign addrPhase = state_q inside {ADDRISSUE, ADDRWAIT};

  assign oCMDReady          = (state_q == IDLE);
  assign oLastStep          = (state_q == DONE);
  assign oWayTimeout        = timeout_q;
  assign oACG_TargetWay     = target_q;
  assign oACG_Command       = caActive ? 8'h40 : 8'h00;
  assign oACG_CommandOption = 3'b000;
  assign oACG_NumOfData     = caActive ? 16'd1 : 16'd0;
  assign oACG_CASelect      = ~addrPhase;
  assign oACG_CAData        = caActive ? {(addrPhase ? lun_q : cmdByte), 32'h0} : 40'h0;

endmodule

// File: doc/nfc_command_reset_seq.md
Name: nfc_command_reset_seq

Overview:
Parametrised successor to the single-shot NAND reset command block. It accepts a reset command from the NFC command dispatcher and drives the atomic command generator (ACG) CA path. Three reset flavours are supported: FFh RESET, FCh SYNC RESET, and FAh RESET LUN (command plus one address cycle). Selected ways are reset either in parallel or one way at a time, with R/B low-window and R/B high-timeout supervision and per-way timeout status.

Parameters:
NumberOfWays, 4, number of chip-enable ways (way mask width)
CommandID, 6'b000001, opcode this block decodes
TargetID, 5'b00101, target ID this block decodes
RBLowWindow, 64, cycles to wait for R/B low before treating it as already complete
TimeoutWidth, 24, width of the R/B-high timeout counter
TimeoutLimit, 24'hFFFFFF, cycles allowed for R/B high before timeout

Ports:
iSystemClock in 1 system clock, all logic on rising edge
iReset in 1 asynchronous, active-low reset
iOpcode in 6 command opcode
iTargetID in 5 command target
iSourceID in 5 command source (unused, accepted)
iAddress in 32 [1:0] mode (00=FFh, 01=FCh, 10=FAh, 11=FFh); [4] 1=sequential ways; [15:8] LUN byte for FAh
iCMDValid in 1 command valid
oCMDReady out 1 ready to accept a command
iWaySelect in NumberOfWays ways to reset
oStart out 1 combinational decode: opcode and target match, and iCMDValid
oLastStep out 1 one-cycle completion pulse
oWayTimeout out NumberOfWays sticky per-way timeout flags for the last command
oACG_Command out 8 ACG one-hot command; bit6 = CA issue
oACG_CommandOption out 3 always 0
iACG_Ready in 8 ACG ready vector; bits [6:0] all 1 = idle
iACG_LastStep in 8 ACG last-step vector; bit6 = CA done
oACG_TargetWay out NumberOfWays way(s) currently driven
oACG_NumOfData out 16 CA byte count
oACG_CASelect out 1 1=command latch, 0=address latch
oACG_CAData out 40 CA byte in [39:32], rest 0
iACG_ReadyBusy in NumberOfWays raw R/B per way, 1=ready

Behaviour:
- Reset (iReset=0, asynchronous): all outputs take their reset values and the FSM goes to IDLE. Reset values: oCMDReady=1, oLastStep=0, oWayTimeout=0, oACG_Command=0, oACG_CommandOption=0, oACG_TargetWay=0, oACG_NumOfData=0, oACG_CASelect=1, oACG_CAData=0.
- Reset asserted mid-sequence: the sequence is abandoned and no oLastStep is produced.
- Accept: a command is accepted on a clock edge with oStart & oCMDReady. At acceptance, latch the mode, the sequential bit, the LUN byte, and the mask (iWaySelect); clear oWayTimeout; drop oCMDReady next cycle.
- Sequential mode: ways are reset one at a time, lowest set bit first, with oACG_TargetWay one-hot.
- Parallel mode: all masked ways are reset together, with oACG_TargetWay = mask.
- Empty mask: oLastStep pulses 2 cycles after acceptance and there is no ACG activity.
- R/B path: a 2-stage register of (oACG_TargetWay & iACG_ReadyBusy). wRB is the OR of the stage-2 bits. In parallel mode, the AND of the masked bits is used for the high check.
- FSM states: IDLE, SELWAY, CMDISSUE, CMDWAIT, ADDRISSUE, ADDRWAIT, WAITRBLOW, WAITRBHIGH, NEXTWAY, DONE.
- SELWAY: load oACG_TargetWay from the remaining mask (or the full mask in parallel mode) -> CMDISSUE.
- CMDISSUE: hold oACG_Command=0x40, NumOfData=1, CASelect=1, CAData[39:32]=FFh/FCh/FAh. Leave when iACG_Ready[6:0] is all ones -> CMDWAIT.
- CMDWAIT: hold the CA outputs until iACG_LastStep[6]. Then go to ADDRISSUE if mode=FAh, else WAITRBLOW; oACG_Command returns to 0.
- ADDRISSUE/ADDRWAIT: same handshake as CMDISSUE/CMDWAIT with CASelect=0 and CAData[39:32]=LUN -> WAITRBLOW.
- WAITRBLOW: the low-window counter counts up from 0. If wRB==0 -> WAITRBHIGH. If the counter reaches RBLowWindow-1 -> WAITRBHIGH anyway.
- WAITRBHIGH: the timeout counter counts up from 0.
  - R/B ready -> NEXTWAY.
  - Counter reaches TimeoutLimit -> set oWayTimeout bits for the current TargetWay, then -> NEXTWAY.
  - If both happen in the same cycle, R/B ready wins and there is no timeout.
- NEXTWAY: clear the serviced bit(s) from the remaining mask. If bits remain -> SELWAY, else DONE.
- DONE: oLastStep=1 for one cycle, oACG_TargetWay holds its value -> IDLE. oCMDReady=1 from the cycle after DONE.
- Counters: both clear on every state entry and saturate, never wrapping.
- CA outputs: oACG_Command=0 in all states other than CMDISSUE/CMDWAIT/ADDRISSUE/ADDRWAIT.
- oStart asserts regardless of oCMDReady. While busy, a matching command is not accepted and does not disturb the sequence.

Test Plan:
- Parallel FFh, mask 4'b0101: ACG ready, LastStep[6] after 3 cycles, R/B of ways 0/2 low for 20 cycles -> one CA transfer of FFh with TargetWay=0101, CASelect=1, NumOfData=1; single oLastStep pulse; oWayTimeout=0.
- Sequential FCh, mask 4'b1011 -> three CA transfers of FCh with TargetWay 0001, 0010, 1000 in order; each waits its own R/B; one oLastStep at the end.
- FAh, LUN=8'h03, mask 4'b0010 -> CA transfer FAh (CASelect=1), then CA transfer 03h (CASelect=0), then R/B wait, then oLastStep.
- R/B never falls, RBLowWindow=8 -> WAITRBLOW exits after 8 cycles; R/B already high -> done without timeout.
- R/B stuck low on way 1 of mask 4'b0011 sequential, TimeoutLimit=100 -> oWayTimeout=4'b0010; way 0 completes normally; oLastStep fires.
- iReset low during WAITRBHIGH -> outputs at reset values immediately; no oLastStep. Empty mask command -> oLastStep 2 cycles after acceptance, oACG_Command stays 0.
